frame_timing_ctrl: RTL and testbench

Sequencer for the frame pattern generator. Produces camera-style frame timing (fval, lval, dval) plus the single-cycle lval_negedge and fval_posedge strobes the pattern generator consumes. Also owns the pattern select, changing it only at frame boundaries, either from a host load or by auto-cycling through the implemented patterns. Sits between host/config logic and the pattern generator.

---
 rtl/frame_timing_ctrl.sv | 176 +++++++++++++++++
 tb/tb_frame_timing_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_timing_ctrl.sv
// Frame timing sequencer: generates fval/lval/dval and the edge strobes consumed by the
// pattern generator, and owns the pattern select, which only changes at frame start.
module frame_timing_ctrl #(
  parameter int unsigned DVAL_HIGH          = 640,
  parameter int unsigned ROW_COUNT          = 480,
  parameter int unsigned F_PORCH            = 4,
  parameter int unsigned H_BLANK            = 16,
  parameter int unsigned V_BLANK            = 64,
  parameter int unsigned FRAMES_PER_PATTERN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        auto_cycle,
  input  logic [2:0]  sel_in,
  input  logic        sel_load,
  output logic        fval,
  output logic        lval,
  output logic        dval,
  output logic        lval_negedge,
  output logic        fval_posedge,
  output logic [2:0]  sel,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam logic [15:0] FpLast  = 16'(F_PORCH - 1);
  localparam logic [15:0] DvLast  = 16'(DVAL_HIGH - 1);
  localparam logic [15:0] HbLast  = 16'(H_BLANK - 1);
  localparam logic [15:0] VbLast  = 16'(V_BLANK - 1);
  localparam logic [15:0] RowLast = 16'(ROW_COUNT - 1);
  localparam logic [15:0] FppVal  = 16'(FRAMES_PER_PATTERN);

  typedef enum logic [2:0] {
    StIdle,
    StFvStart,
    StLineActive,
    StLineBlank,
    StVBlank
  } state_e;

  state_e      state;
  logic [15:0] cnt;        // cycles spent in the current state
  logic [15:0] line_cnt;   // lines completed in the current frame
  logic [15:0] auto_cnt;   // frames started since the last sel change
  logic [2:0]  pend_sel;
  logic        pend_valid;
  logic        start_frame;

  // Auto-cycle order: 0 -> 1 -> 2 -> 3 -> 7 -> 0; anything else restarts at 0.
  function automatic logic [2:0] next_sel(input logic [2:0] cur);
    logic [2:0] nxt;
    case (cur)
      3'd0:    nxt = 3'd1;
      3'd1:    nxt = 3'd2;
      3'd2:    nxt = 3'd3;
      3'd3:    nxt = 3'd7;
      default: nxt = 3'd0;
    endcase
    return nxt;
  endfunction

  // A frame starts from IDLE or at the last V_BLANK cycle whenever enable is high.
  always_comb begin
    start_frame = 1'b0;
    if (state == StIdle) begin
      start_frame = enable;
    end else if ((state == StVBlank) && (cnt == VbLast)) begin
      start_frame = enable;
    end
  end

  // Sequencer state, counters, pending select and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      cnt          <= '0;
      line_cnt     <= '0;
      auto_cnt     <= '0;
      pend_sel     <= '0;
      pend_valid   <= 1'b0;
      fval         <= 1'b0;
      lval         <= 1'b0;
      dval         <= 1'b0;
      lval_negedge <= 1'b0;
      fval_posedge <= 1'b0;
      busy         <= 1'b0;
      sel          <= '0;
      frame_count  <= '0;
    end else begin
      fval_posedge <= 1'b0;
      lval_negedge <= 1'b0;
      cnt          <= cnt + 16'd1;

      // A load coinciding with frame start is kept for the following frame.
      if (sel_load) begin
        pend_sel   <= sel_in;
        pend_valid <= 1'b1;
      end else if (start_frame && pend_valid) begin
        pend_valid <= 1'b0;
      end

      if (start_frame) begin
        state        <= StFvStart;
        cnt          <= '0;
        line_cnt     <= '0;
        fval         <= 1'b1;
        lval         <= 1'b0;
        dval         <= 1'b0;
        fval_posedge <= 1'b1;
        busy         <= 1'b1;
        frame_count  <= frame_count + 16'd1;
        // Counter is cleared on a change, then counts this frame.
        if (pend_valid) begin
          sel      <= pend_sel;
          auto_cnt <= 16'd1;
        end else if (auto_cycle && (auto_cnt == FppVal)) begin
          sel      <= next_sel(sel);
          auto_cnt <= 16'd1;
        end else begin
          auto_cnt <= auto_cnt + 16'd1;
        end
      end else begin
        case (state)
          StIdle: begin
            cnt <= '0;
          end
          StFvStart: begin
            if (cnt == FpLast) begin
              state <= StLineActive;
              cnt   <= '0;
              lval  <= 1'b1;
              dval  <= 1'b1;
            end
          end
          StLineActive: begin
            if (cnt == DvLast) begin
              cnt          <= '0;
              lval         <= 1'b0;
              dval         <= 1'b0;
              lval_negedge <= 1'b1;
              line_cnt     <= line_cnt + 16'd1;
              if (line_cnt == RowLast) begin
                state <= StVBlank;
                fval  <= 1'b0;
              end else begin
                state <= StLineBlank;
              end
            end
          end
          StLineBlank: begin
            if (cnt == HbLast) begin
              state <= StLineActive;
              cnt   <= '0;
              lval  <= 1'b1;
              dval  <= 1'b1;
            end
          end
          StVBlank: begin
            if (cnt == VbLast) begin
              state <= StIdle;
              cnt   <= '0;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= StIdle;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_timing_ctrl.sv
// Bench for frame_timing_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a frame-position reference model.
module tb_frame_timing_ctrl;

  localparam int DV     = 8;
  localparam int RC     = 4;
  localparam int FP     = 2;
  localparam int HB     = 3;
  localparam int VB     = 5;
  localparam int FPP    = 2;
  localparam int FV_LEN = FP + RC * DV + (RC - 1) * HB;
  localparam int PERIOD = FV_LEN + VB;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        auto_cycle;
  logic [2:0]  sel_in;
  logic        sel_load;
  logic        fval;
  logic        lval;
  logic        dval;
  logic        lval_negedge;
  logic        fval_posedge;
  logic [2:0]  sel;
  logic [15:0] frame_count;
  logic        busy;
  logic        force_fc;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state: position within the current frame plus select bookkeeping.
  bit m_run;
  int m_pos;
  int m_sel;
  int m_fc;
  bit m_pend_v;
  int m_pend;
  int m_auto;
  int seq_next[8] = '{1, 2, 3, 7, 0, 0, 0, 0};

  frame_timing_ctrl #(
    .DVAL_HIGH          (DV),
    .ROW_COUNT          (RC),
    .F_PORCH            (FP),
    .H_BLANK            (HB),
    .V_BLANK            (VB),
    .FRAMES_PER_PATTERN (FPP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .auto_cycle   (auto_cycle),
    .sel_in       (sel_in),
    .sel_load     (sel_load),
    .fval         (fval),
    .lval         (lval),
    .dval         (dval),
    .lval_negedge (lval_negedge),
    .fval_posedge (fval_posedge),
    .sel          (sel),
    .frame_count  (frame_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit start;
    if (!rst) begin
      m_run = 0; m_pos = 0; m_sel = 0; m_fc = 0;
      m_pend_v = 0; m_pend = 0; m_auto = 0;
    end else begin
      start = 0;
      if (!m_run) start = enable;
      else if (m_pos == PERIOD - 1) begin
        if (enable) start = 1;
        else m_run = 0;
      end else m_pos++;
      if (start) begin
        m_run = 1;
        m_pos = 0;
        m_fc  = (m_fc + 1) % 65536;
        if (m_pend_v) begin
          m_sel = m_pend; m_pend_v = 0; m_auto = 1;
        end else if (auto_cycle && m_auto == FPP) begin
          m_sel = seq_next[m_sel]; m_auto = 1;
        end else m_auto = (m_auto + 1) % 65536;
      end
      if (sel_load) begin
        m_pend = int'(sel_in); m_pend_v = 1;
      end
      if (force_fc) m_fc = 65535;
    end
  endtask

  function automatic logic [24:0] model_out();
    int  p;
    bit  fv, lv, ln;
    p  = m_pos - FP;
    fv = m_run && (m_pos < FV_LEN);
    lv = m_run && (m_pos >= FP) && (p < RC * (DV + HB) - HB) && ((p % (DV + HB)) < DV);
    ln = m_run && (p >= DV) && (((p - DV) % (DV + HB)) == 0) && (((p - DV) / (DV + HB)) < RC);
    return {fv, lv, lv, ln, m_run && (m_pos == 0), m_run, 3'(m_sel), 16'(m_fc)};
  endfunction

  task automatic monitor();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("cycle_outputs",
            {fval, lval, dval, lval_negedge, fval_posedge, busy, sel, frame_count}, model_out());
    end
  endtask

  // Called on cycle 0 of a frame; returns after PERIOD cycles.
  task automatic measure_frame(output int nd, output int nl, output int nf);
    nd = 0; nl = 0; nf = 0;
    for (int i = 0; i < PERIOD; i++) begin
      nd += int'(dval);
      nl += int'(lval_negedge);
      nf += int'(fval);
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag);
    int nd, nl, nf;
    measure_frame(nd, nl, nf);
    check({tag, "_dval_cycles"}, nd, 32);
    check({tag, "_lval_negedge_pulses"}, nl, 4);
    check({tag, "_fval_cycles"}, nf, 43);
    check({tag, "_period"}, fval_posedge, 1);
  endtask

  initial begin
    int auto_exp[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 7, 7, 0};
    int n;
    rst = 1'b0; enable = 1'b0; auto_cycle = 1'b0; sel_in = '0; sel_load = 1'b0;
    force_fc = 1'b0;
    fork
      monitor();
    join_none

    // Reset state and start latency.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {fval, lval, dval, lval_negedge, fval_posedge, busy, sel, frame_count}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    enable = 1'b1;
    @(negedge clk);
    check("start_latency", {fval, fval_posedge, busy}, 3'b111);
    for (int f = 1; f <= 3; f++) begin
      check("frame_count", frame_count, f);
      check_frame("run");
    end

    // Auto-cycle sequence from a fresh reset.
    rst = 1'b0;
    @(negedge clk);
    auto_cycle = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 11; f++) begin
      check("auto_fval_posedge", fval_posedge, 1);
      check("auto_sel", sel, auto_exp[f]);
      repeat (PERIOD) @(negedge clk);
    end

    // Pending select loads.
    rst = 1'b0;
    @(negedge clk);
    auto_cycle = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    sel_load = 1'b1; sel_in = 3'd3;
    @(negedge clk);
    sel_load = 1'b0;
    check("sel_hold_mid_frame", sel, 0);
    repeat (37) @(negedge clk);
    check("sel_load_applied", sel, 3);
    repeat (5) @(negedge clk);
    sel_load = 1'b1; sel_in = 3'd2;
    @(negedge clk);
    sel_load = 1'b0;
    repeat (10) @(negedge clk);
    sel_load = 1'b1; sel_in = 3'd5;
    @(negedge clk);
    sel_load = 1'b0;
    repeat (30) @(negedge clk);
    sel_load = 1'b1; sel_in = 3'd6;
    @(negedge clk);
    sel_load = 1'b0;
    check("sel_last_load_wins", sel, 5);
    repeat (PERIOD) @(negedge clk);
    check("sel_load_at_boundary", sel, 6);

    // enable dropped during line 2.
    repeat (15) @(negedge clk);
    enable = 1'b0;
    repeat (33) @(negedge clk);
    check("idle_after_drop", {fval, busy, fval_posedge}, 0);
    n = 0;
    repeat (30) begin
      n += int'(fval_posedge);
      @(negedge clk);
    end
    check("no_restart", n, 0);
    enable = 1'b1;
    @(negedge clk);
    check("restart_latency", fval_posedge, 1);

    // Asynchronous reset during LINE_ACTIVE.
    repeat (4) @(negedge clk);
    check("pre_reset_lval", lval, 1);
    #2 rst = 1'b0;
    #1 check("async_reset",
             {fval, lval, dval, lval_negedge, fval_posedge, busy, sel, frame_count}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_restart", fval_posedge, 1);
    check_frame("post_reset");

    // frame_count wrap.
    enable = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_for_wrap", busy, 0);
    force_fc = 1'b1;
    force dut.frame_count = 16'hffff;
    @(negedge clk);
    release dut.frame_count;
    force_fc = 1'b0;
    check("fc_preset", frame_count, 16'hffff);
    enable = 1'b1;
    @(negedge clk);
    check("fc_wrap", frame_count, 0);

    // Randomized run, checked by the per-cycle model.
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 99) < 90);
      if ($urandom_range(0, 199) == 0) auto_cycle = ~auto_cycle;
      sel_load = ($urandom_range(0, 29) == 0);
      sel_in   = 3'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    rst = 1'b1; sel_load = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
